// File: rtl/ai_coproc_responder.sv
// Sequential AI coprocessor responder: one shared signed 8x8 MAC behind a start/busy/done handshake.
// Define AI_COPROC_SAT_EN to saturate matmul elements to int8; otherwise they wrap.
module ai_coproc_responder #(
    parameter int                 ACC_W       = 32,
    parameter logic signed [31:0] STEP_THRESH = 32'sd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        err
);

    localparam logic [2:0] OP_DOT    = 3'b000;
    localparam logic [2:0] OP_MATMUL = 3'b001;
    localparam logic [2:0] OP_RELU   = 3'b010;
    localparam logic [2:0] OP_STEP   = 3'b011;
    localparam int         WIDE_W    = (ACC_W > 32) ? ACC_W : 32;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [31:0]              a_q, a_d, b_q, b_d;
    logic [4:0]               rd_q, rd_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [23:0]              pack_q, pack_d;
    logic [31:0]              result_q, result_d;
    logic                     err_q, err_d;

    logic [1:0]               lane_a, lane_b;
    logic signed [7:0]        mac_a, mac_b;
    logic signed [15:0]       product;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [WIDE_W-1:0] acc_wide;
    logic [7:0]               elem;
    logic [2:0]               last_cnt;

    // Matmul walks C00,C01,C10,C11 with two MACs each: cnt = {i, j, k}.
    always_comb begin
        if (op_q == OP_MATMUL) begin
            lane_a = {cnt_q[2], cnt_q[0]};
            lane_b = {cnt_q[0], cnt_q[1]};
        end else begin
            lane_a = cnt_q[1:0];
            lane_b = cnt_q[1:0];
        end
        mac_a    = a_q[8*lane_a +: 8];
        mac_b    = b_q[8*lane_b +: 8];
        product  = mac_a * mac_b;
        acc_sum  = acc_q + ACC_W'(product);
        acc_wide = WIDE_W'(acc_sum);
`ifdef AI_COPROC_SAT_EN
        if (acc_wide > WIDE_W'(127))
            elem = 8'h7F;
        else if (acc_wide < -WIDE_W'(128))
            elem = 8'h80;
        else
            elem = acc_wide[7:0];
`else
        elem = acc_wide[7:0];
`endif
        case (op_q)
            OP_DOT:    last_cnt = 3'd3;
            OP_MATMUL: last_cnt = 3'd7;
            default:   last_cnt = 3'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pack_d   = pack_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPUTE;
                    op_d    = opcode;
                    a_d     = a;
                    b_d     = b;
                    rd_d    = rd_in;
                    acc_d   = '0;
                    cnt_d   = 3'd0;
                    pack_d  = '0;
                    err_d   = 1'b0;
                end
            end
            COMPUTE: begin
                cnt_d = cnt_q + 3'd1;
                case (op_q)
                    OP_DOT: begin
                        acc_d = acc_sum;
                        if (cnt_q == last_cnt)
                            result_d = acc_wide[31:0];
                    end
                    OP_MATMUL: begin
                        if (cnt_q[0]) begin
                            acc_d  = '0;
                            pack_d = {elem, pack_q[23:8]};
                            if (cnt_q == last_cnt)
                                result_d = {elem, pack_q};
                        end else begin
                            acc_d = acc_sum;
                        end
                    end
                    OP_RELU:  result_d = a_q[31] ? 32'd0 : a_q;
                    OP_STEP:  result_d = ($signed(a_q) >= STEP_THRESH) ? 32'd1 : 32'd0;
                    default: begin
                        result_d = 32'd0;
                        err_d    = 1'b1;
                    end
                endcase
                if (cnt_q == last_cnt)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pack_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pack_q   <= pack_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign rd_out = rd_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ai_coproc_responder.sv
// Scoreboard bench for ai_coproc_responder: driver pushes reference-model results, monitor checks on done.
module tb_ai_coproc_responder;

    localparam logic [2:0]         OP_DOT      = 3'b000;
    localparam logic [2:0]         OP_MATMUL   = 3'b001;
    localparam logic [2:0]         OP_RELU     = 3'b010;
    localparam logic [2:0]         OP_STEP     = 3'b011;
    localparam logic signed [31:0] STEP_THRESH = 32'sd0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
        int          lat;
        int          accCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opcode = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, err;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t expQ[$];
    exp_t monExp;
    logic holdPending = 1'b0;
    logic [31:0] holdVal = '0;

    ai_coproc_responder #(.ACC_W(32), .STEP_THRESH(STEP_THRESH)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: lanes as plain ints, matrix product by explicit loops.
    function automatic exp_t refModel(input logic [2:0] op, input logic [31:0] av,
                                      input logic [31:0] bv, input logic [4:0] rd);
        exp_t e;
        int al[4];
        int bl[4];
        int s;
        int c;
        logic [31:0] cv;
        for (int i = 0; i < 4; i++) begin
            al[i] = $signed(av[8*i +: 8]);
            bl[i] = $signed(bv[8*i +: 8]);
        end
        e.rd = rd;
        e.err = 1'b0;
        e.res = '0;
        e.accCyc = 0;
        case (op)
            OP_DOT: begin
                s = 0;
                for (int i = 0; i < 4; i++) s += al[i] * bl[i];
                e.res = s;
                e.lat = 4;
            end
            OP_MATMUL: begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        c = al[2*i] * bl[j] + al[2*i+1] * bl[2+j];
`ifdef AI_COPROC_SAT_EN
                        if (c > 127) c = 127;
                        else if (c < -128) c = -128;
`endif
                        cv = c;
                        e.res[8*(2*i+j) +: 8] = cv[7:0];
                    end
                e.lat = 8;
            end
            OP_RELU: begin
                e.res = av[31] ? 32'd0 : av;
                e.lat = 1;
            end
            OP_STEP: begin
                e.res = ($signed(av) >= STEP_THRESH) ? 32'd1 : 32'd0;
                e.lat = 1;
            end
            default: begin
                e.err = 1'b1;
                e.lat = 1;
            end
        endcase
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding command.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("result", result, monExp.res);
                    checkOutput("rd_out", {27'd0, rd_out}, {27'd0, monExp.rd});
                    checkOutput("err", {31'd0, err}, {31'd0, monExp.err});
                    checkOutput("latency", cyc - monExp.accCyc, monExp.lat);
                    holdPending = 1'b1;
                    holdVal = monExp.res;
                end
            end else if (holdPending) begin
                holdPending = 1'b0;
                checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
                checkOutput("result_hold", result, holdVal);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) checkOutput("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic startCmd(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                            input logic [4:0] rd, input bit expectDone);
        exp_t e;
        waitIdle();
        opcode = op; a = av; b = bv; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (expectDone) begin
            e = refModel(op, av, bv, rd);
            e.accCyc = cyc;
            expQ.push_back(e);
        end
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
        a = $urandom; b = $urandom; opcode = 3'($urandom_range(0, 7)); rd_in = 5'($urandom_range(0, 31));
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [4:0] rd);
        startCmd(op, av, bv, rd, 1'b1);
        waitIdle();
    endtask

    initial begin
        logic [2:0] rop;
        $display("[TB] starting");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(OP_DOT, 32'h04030201, 32'h01010101, 5'd7);
        applyStimulus(OP_DOT, 32'hFFFFFFFF, 32'h02020202, 5'd3);
        applyStimulus(OP_MATMUL, 32'h04030201, 32'h01000001, 5'd9);
        applyStimulus(OP_MATMUL, 32'h7F7F7F7F, 32'h7F7F7F7F, 5'd10);
        applyStimulus(OP_MATMUL, 32'h80808080, 32'h80808080, 5'd11);
        applyStimulus(OP_RELU, 32'h80000005, 32'h0, 5'd12);
        applyStimulus(OP_RELU, 32'h00000123, 32'h0, 5'd13);
        applyStimulus(OP_STEP, 32'hFFFFFFFF, 32'h0, 5'd14);
        applyStimulus(OP_STEP, 32'h00000000, 32'h0, 5'd15);
        applyStimulus(3'b111, 32'h12345678, 32'h9ABCDEF0, 5'd16);
        applyStimulus(OP_RELU, 32'h00000042, 32'h0, 5'd17);

        // A start with a new tag while busy must be dropped.
        startCmd(OP_MATMUL, 32'h04030201, 32'h01000001, 5'd7, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        opcode = OP_DOT; rd_in = 5'd21; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitIdle();

        // Reset mid-command aborts it; the next start is accepted normally.
        startCmd(OP_MATMUL, 32'h11223344, 32'h55667788, 5'd25, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        applyStimulus(OP_DOT, 32'h01020304, 32'hFF01FF01, 5'd26);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 8) rop = 3'($urandom_range(0, 3));
            else rop = 3'($urandom_range(4, 7));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            applyStimulus(rop, $urandom, $urandom, 5'($urandom_range(0, 31)));
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ai_coproc_responder.md
Name: ai_coproc_responder

Overview:
- Responder side of the AI start/busy/done handshake that the pipeline EX stage drives.
- Accepts one command: opcode, two packed 32-bit operands and a destination-register tag. Runs it on a single shared signed 8x8 MAC, one MAC per cycle.
- Returns the result and the tag with a one-cycle done pulse.
- Replaces the split matrix_multiplier plus ai_unit_controller pair with one sequential unit that owns busy/done.

Parameters:
- ACC_W, 32: accumulator width in bits; must be >= 18; result is the low 32 bits, sign-extended if ACC_W < 32.
- STEP_THRESH, 0: signed 32-bit threshold for the step opcode.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only when busy=0.
- opcode  input  3  000 dot, 001 matmul 2x2, 010 relu, 011 step, others unsupported.
- a  input  32  operand A; lane i = a[8i+7:8i], signed int8.
- b  input  32  operand B, same packing as a.
- rd_in  input  5  destination tag, latched with the command.
- busy  output  1  high from the cycle after acceptance through the done cycle, inclusive.
- done  output  1  single-cycle completion pulse.
- result  output  32  result; held stable from done until the next acceptance.
- rd_out  output  5  latched tag; valid with done.
- err  output  1  high with done for an unsupported opcode; holds until the next acceptance.

Behaviour:
- Reset: busy=0, done=0, result=0, rd_out=0, err=0, FSM=IDLE, accumulator and counter cleared.
- Reset has priority over everything. Reset mid-operation aborts the command: no done is produced and IDLE is reached on the next cycle.
- FSM states: IDLE, COMPUTE, DONE.
  - IDLE -> COMPUTE when start=1 at a clock edge. a, b, opcode and rd_in are latched; acc=0; cnt=0.
  - COMPUTE performs one step per cycle for N cycles, then -> DONE.
  - DONE asserts done=1 for one cycle, then -> IDLE.
- Latency: start sampled in cycle T -> busy=1 from T+1, compute in T+1..T+N, done in T+N+1, busy=0 from T+N+2.
  - N=4 for dot, N=8 for matmul, N=1 for relu, step and unsupported opcodes.
- start while busy=1, including the DONE cycle, is ignored and not queued. Back-to-back commands therefore need a start in T+N+2 or later.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- dot: acc += a_i*b_i for i=0..3, signed; result = acc.
- matmul:
  - A = [[a0,a1],[a2,a3]], B = [[b0,b1],[b2,b3]], C_ij = sum_k A_ik*B_kj.
  - Order: C00, C01, C10, C11, two MACs each. acc is cleared between elements.
  - Each element is reduced to 8 bits (see Optional Feature) and packed as result = {C11,C10,C01,C00}.
- relu: result = a[31] ? 0 : a, treating a as signed 32-bit.
- step: result = ($signed(a) >= STEP_THRESH) ? 1 : 0.
- Unsupported opcode: result=0, err=1.
- err=0 for all supported opcodes.

Optional Feature:
- Macro AI_COPROC_SAT_EN.
- Defined: each matmul element saturates to [-128,127] before packing.
- Undefined: each element is truncated to its low 8 bits (wrap).
- dot, relu and step are unaffected either way.

Test Plan:
- dot, a=0x04030201, b=0x01010101, start in T -> busy=1 from T+1; done=1 only in T+5; result=0x0000000A; rd_out=rd_in (e.g. 5'd7); busy=0 in T+6.
- dot, a=0xFFFFFFFF, b=0x02020202 -> result=0xFFFFFFF8 at T+5.
- matmul, a=0x04030201, b=0x01000001 (identity) -> done at T+9, result=0x04030201.
- matmul, a=b=0x7F7F7F7F:
  - with AI_COPROC_SAT_EN -> result=0x7F7F7F7F.
  - without AI_COPROC_SAT_EN -> result=0x02020202 (32258 = 0x7E02).
- relu and step:
  - relu, a=0x80000005 -> result=0 at T+2.
  - relu, a=0x00000123 -> result=0x123 at T+2.
  - step, a=0xFFFFFFFF -> result=0 at T+2.
  - opcode 3'b111 -> done at T+2, result=0, err=1.
- Control:
  - matmul started in T; a second start with a new tag in T+3 -> ignored, the first command's tag and result appear at T+9.
  - reset in T+3 -> busy=0 and done=0 from T+4, no done ever for that command.
  - start in T+4 is accepted normally.
